// File: rtl/pulse_monitor.sv
// pulse_monitor
// Measures the edge-to-edge interval of a periodic pulse against a nominal
// period and flags early, late or missing pulses. Tracks lock after a run of
// in-tolerance intervals.
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   en           monitor enable; low forces IDLE
//   pulse_in     periodic pulse, synchronous to clk
//   clr_err      strobe clearing err_sticky and miss_cnt
//   period       last measured interval in cycles
//   period_valid one-cycle strobe, period updated
//   early_err    one-cycle strobe, interval below MIN_P
//   late_err     one-cycle strobe, interval above MAX_P or pulse missing
//   err_sticky   latched error flag
//   locked       LOCK_COUNT consecutive good intervals, no error since
//   miss_cnt     saturating count of late_err events
//
// state   | meaning
// IDLE    | monitor disabled
// ACQUIRE | enabled, waiting for the first edge to start timing
// TRACK   | timing intervals between edges
module pulse_monitor #(
  parameter int CLKFREQ_HZ = 24000000,
  parameter int TOL_CYCLES = 1000,
  parameter int LOCK_COUNT = 2,
  localparam int MIN_P = CLKFREQ_HZ - TOL_CYCLES,
  localparam int MAX_P = CLKFREQ_HZ + TOL_CYCLES,
  localparam int CNTR_WIDTH = $clog2(MAX_P + 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  pulse_in,
  input  logic                  clr_err,
  output logic [CNTR_WIDTH-1:0] period,
  output logic                  period_valid,
  output logic                  early_err,
  output logic                  late_err,
  output logic                  err_sticky,
  output logic                  locked,
  output logic [7:0]            miss_cnt
);

  localparam int GW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [CNTR_WIDTH-1:0] MIN_V = CNTR_WIDTH'(MIN_P);
  localparam logic [CNTR_WIDTH-1:0] MAX_V = CNTR_WIDTH'(MAX_P);
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} state_t;

  state_t                state;
  state_t                state_next;
  logic                  pulse_in_d;
  logic [CNTR_WIDTH-1:0] cntr;
  logic [GW-1:0]         good_run;

  logic                  pulse_edge;
  logic                  in_track;
  logic [CNTR_WIDTH-1:0] interval;
  logic                  late_hit;
  logic                  early_hit;
  logic                  good_hit;

  always_comb begin
    state_next = state;
    if (!en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = ACQUIRE;
        ACQUIRE: if (pulse_edge) state_next = TRACK;
        TRACK:   state_next = TRACK;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A timeout takes priority over an early classification, so an edge that
  // lands exactly on the timeout reports a single late error.
  always_comb begin
    pulse_edge = pulse_in & ~pulse_in_d;
    in_track   = en && (state == TRACK);
    interval   = cntr + 1'b1;
    late_hit   = in_track && (cntr == MAX_V);
    early_hit  = in_track && pulse_edge && !late_hit && (interval < MIN_V);
    good_hit   = in_track && pulse_edge && !late_hit && !early_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_in_d   <= 1'b0;
      cntr         <= '0;
      good_run     <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      early_err    <= 1'b0;
      late_err     <= 1'b0;
      err_sticky   <= 1'b0;
      locked       <= 1'b0;
      miss_cnt     <= '0;
    end else begin
      pulse_in_d   <= pulse_in;
      period_valid <= 1'b0;
      early_err    <= early_hit;
      late_err     <= late_hit;

      if (in_track) begin
        if (pulse_edge || late_hit) cntr <= '0;
        else                        cntr <= cntr + 1'b1;
        if (pulse_edge) begin
          period       <= interval;
          period_valid <= 1'b1;
        end
      end else begin
        cntr <= '0;
      end

      if (!in_track || late_hit || early_hit) begin
        good_run <= '0;
        locked   <= 1'b0;
      end else if (good_hit) begin
        if (good_run != GOOD_MAX) good_run <= good_run + 1'b1;
        locked <= (good_run >= GOOD_MAX - GW'(1));
      end

      // A new error wins over a coincident clear.
      if (late_hit || early_hit) err_sticky <= 1'b1;
      else if (clr_err)          err_sticky <= 1'b0;

      if (late_hit) begin
        if (clr_err)                miss_cnt <= 8'd1;
        else if (miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 1'b1;
      end else if (clr_err) begin
        miss_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_monitor.sv
module tb_pulse_monitor;

  localparam int CLKF  = 100;
  localparam int TOL   = 5;
  localparam int LOCKN = 2;
  localparam int MIN_P = CLKF - TOL;
  localparam int MAX_P = CLKF + TOL;
  localparam int W     = $clog2(MAX_P + 2);

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         pulse_in;
  logic         clr_err;
  logic [W-1:0] period;
  logic         period_valid;
  logic         early_err;
  logic         late_err;
  logic         err_sticky;
  logic         locked;
  logic [7:0]   miss_cnt;

  pulse_monitor #(
    .CLKFREQ_HZ(CLKF),
    .TOL_CYCLES(TOL),
    .LOCK_COUNT(LOCKN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .pulse_in(pulse_in),
    .clr_err(clr_err),
    .period(period),
    .period_valid(period_valid),
    .early_err(early_err),
    .late_err(late_err),
    .err_sticky(err_sticky),
    .locked(locked),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: works on time stamps. A reference point is the cycle of
  // the last timed edge or timeout; the interval is simply now minus that.
  int m_mode;      // 0 disabled, 1 waiting for first edge, 2 timing
  int m_ref;
  int m_good;
  int m_period;
  int m_miss;
  bit m_prev;
  bit m_locked;
  bit m_sticky;
  bit m_pv;
  bit m_early;
  bit m_late;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step();
    bit edge_seen;
    int elapsed;
    bit is_late;
    bit is_early;
    edge_seen = pulse_in && !m_prev;
    if (rst) begin
      m_mode = 0; m_good = 0; m_locked = 0; m_sticky = 0; m_miss = 0;
      m_period = 0; m_pv = 0; m_early = 0; m_late = 0; m_prev = 0;
      return;
    end
    m_pv = 0; m_early = 0; m_late = 0;
    is_late = 0; is_early = 0;
    if (!en) begin
      m_mode = 0; m_good = 0; m_locked = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (edge_seen) begin
        m_mode = 2;
        m_ref  = cyc;
      end
    end else begin
      elapsed = cyc - m_ref;
      if (edge_seen) begin
        m_period = elapsed;
        m_pv     = 1;
      end
      if (elapsed == MAX_P + 1) is_late = 1;
      else if (edge_seen && elapsed < MIN_P) is_early = 1;
      else if (edge_seen) begin
        m_good   = (m_good + 1 > LOCKN) ? LOCKN : m_good + 1;
        m_locked = (m_good >= LOCKN);
      end
      if (is_late || is_early) begin
        m_good = 0;
        m_locked = 0;
      end
      if (edge_seen || is_late) m_ref = cyc;
    end
    m_early = is_early;
    m_late  = is_late;
    if (is_late || is_early) m_sticky = 1;
    else if (clr_err) m_sticky = 0;
    if (is_late) m_miss = clr_err ? 1 : ((m_miss < 255) ? m_miss + 1 : 255);
    else if (clr_err) m_miss = 0;
    m_prev = pulse_in;
  endtask

  task automatic tick(input logic p, input logic c);
    pulse_in = p;
    clr_err  = c;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    chk("period", int'(period), m_period);
    chk("period_valid", int'(period_valid), int'(m_pv));
    chk("early_err", int'(early_err), int'(m_early));
    chk("late_err", int'(late_err), int'(m_late));
    chk("err_sticky", int'(err_sticky), int'(m_sticky));
    chk("locked", int'(locked), int'(m_locked));
    chk("miss_cnt", int'(miss_cnt), m_miss);
    chk("err_exclusive", int'(early_err & late_err), 0);
  endtask

  // One pulse of random width, then low until the next edge is `interval` away.
  task automatic pulse_gap(input int interval);
    int wdt;
    wdt = $urandom_range(1, (interval > 10) ? 10 : interval - 1);
    for (int i = 0; i < interval; i++) tick(i < wdt, 1'b0);
  endtask

  task automatic idle_cycles(input int n, input logic p, input logic c);
    for (int i = 0; i < n; i++) tick(p, c);
  endtask

  initial begin
    int iv;
    rst = 1'b1; en = 1'b0; pulse_in = 1'b0; clr_err = 1'b0;
    idle_cycles(3, 1'b0, 1'b0);
    rst = 1'b0;
    idle_cycles(2, 1'b0, 1'b0);

    // Nominal pulses, lock after the third edge.
    en = 1'b1;
    idle_cycles(5, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) pulse_gap(100);
    chk("locked_nominal", int'(locked), 1);

    // Early interval, then boundary intervals and relock.
    pulse_gap(94);
    pulse_gap(95);
    pulse_gap(105);
    pulse_gap(100);
    pulse_gap(100);

    // Edge coincident with timeout, then clear.
    pulse_gap(106);
    pulse_gap(100);
    idle_cycles(3, 1'b0, 1'b1);
    idle_cycles(3, 1'b0, 1'b0);

    // Random intervals around tolerance with sporadic clears.
    for (int i = 0; i < 40; i++) begin
      iv = $urandom_range(88, 110);
      for (int k = 0; k < iv; k++)
        tick(k == 0, ($urandom_range(0, 29) == 0));
    end

    // Pulses stop: periodic timeouts.
    for (int i = 0; i < 3; i++) pulse_gap(100);
    idle_cycles(330, 1'b0, 1'b0);

    // Clear held high across a timeout: error wins, miss count restarts at 1.
    idle_cycles(120, 1'b0, 1'b1);

    // Input held high: one edge, timeouts thereafter.
    idle_cycles(300, 1'b1, 1'b0);
    idle_cycles(2, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) pulse_gap(100);

    // Disable mid-track, re-enable: first edge unmeasured.
    en = 1'b0;
    idle_cycles(5, 1'b0, 1'b0);
    en = 1'b1;
    for (int i = 0; i < 4; i++) pulse_gap(100);

    // Reset mid-track.
    rst = 1'b1;
    idle_cycles(2, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) pulse_gap(100);

    // Long silence: miss_cnt saturates.
    idle_cycles(106 * 258, 1'b0, 1'b0);
    chk("miss_saturated", int'(miss_cnt), 255);
    idle_cycles(2, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
